// File: rtl/sigmoid_pkg.sv
// Fixed-point constants shared by the sigmoid forward and backward units.
// Widths are derived from INT_BIT/FRAC_BIT so both units agree on formats.
package sigmoid_pkg;

  localparam int SIGN_BIT     = 1;
  localparam int DEF_INT_BIT  = 7;
  localparam int DEF_FRAC_BIT = 8;

  // Q1.FRAC unsigned width (forward output y)
  function automatic int uq_w(input int frac_bit);
    return 1 + frac_bit;
  endfunction

  // Q-INT.FRAC signed width (gradients)
  function automatic int sq_w(input int int_bit, input int frac_bit);
    return SIGN_BIT + int_bit + frac_bit;
  endfunction

  function automatic int one_of(input int frac_bit);
    return 1 << frac_bit;
  endfunction

  localparam int ONE = 1 << DEF_FRAC_BIT;

endpackage

// File: rtl/sigmoid_deriv.sv
// Sigmoid derivative d = y*(1-y) with y clamped to 1.0.
// Result never exceeds 0.25, so FRAC_BIT bits hold it.
module sigmoid_deriv
  import sigmoid_pkg::*;
#(
  parameter int FRAC_BIT = DEF_FRAC_BIT
) (
  input  logic [FRAC_BIT:0]   y,
  output logic [FRAC_BIT-1:0] d
);

  localparam int UW = uq_w(FRAC_BIT);
  localparam logic [UW-1:0] ONE_Q = UW'(one_of(FRAC_BIT));

  logic [UW-1:0]   yc;
  logic [UW-1:0]   ym;
  logic [2*UW-1:0] prod;

  assign yc   = (y > ONE_Q) ? ONE_Q : y;
  assign ym   = ONE_Q - yc;
  assign prod = yc * ym;
  assign d    = FRAC_BIT'(prod >> FRAC_BIT);

endmodule

// File: rtl/sigmoid_backward.sv
// Sigmoid backward pass: grad_in = grad_out * y * (1 - y).
// Two-stage valid/ready pipeline with bubble collapsing.
module sigmoid_backward
  import sigmoid_pkg::*;
#(
  parameter int INT_BIT  = DEF_INT_BIT,
  parameter int FRAC_BIT = DEF_FRAC_BIT
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [FRAC_BIT:0]                 y,
  input  logic signed [INT_BIT+FRAC_BIT:0]  grad_out,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic signed [INT_BIT+FRAC_BIT:0]  grad_in
);

  localparam int W = sq_w(INT_BIT, FRAC_BIT);

  logic                    s1_valid;
  logic [FRAC_BIT-1:0]     s1_d;
  logic signed [W-1:0]     s1_g;
  logic                    s2_valid;

  logic [FRAC_BIT-1:0]     d;
  logic                    s2_adv;
  logic                    accept;
  logic signed [W+FRAC_BIT:0] prod;
  logic signed [W-1:0]     grad_nxt;

  sigmoid_deriv #(
    .FRAC_BIT(FRAC_BIT)
  ) u_deriv (
    .y(y),
    .d(d)
  );

  assign s2_adv    = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || s2_adv;
  assign accept    = in_valid && in_ready;
  assign out_valid = s2_valid;

  // d is unsigned; zero-extend so the product stays signed
  assign prod     = s1_g * $signed({1'b0, s1_d});
  assign grad_nxt = W'(prod >>> FRAC_BIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      grad_in  <= '0;
    end else begin
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) grad_in <= grad_nxt;
      end
      if (in_ready) s1_valid <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_d <= d;
      s1_g <= grad_out;
    end
  end

endmodule

// File: tb/tb_sigmoid_backward.sv
// Directed bench for sigmoid_backward (INT_BIT=7, FRAC_BIT=8).
// Vector table plus back-to-back, back-pressure and reset sequences.
module tb_sigmoid_backward;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [8:0]         y;
  logic signed [15:0] grad_out;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] grad_in;

  int n_pass;
  int n_total;

  sigmoid_backward #(
    .INT_BIT(7),
    .FRAC_BIT(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .y(y),
    .grad_out(grad_out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .grad_in(grad_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int y;
    int g;
    int exp;
  } vec_t;

  task automatic check(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic run_one(input vec_t v, input int k);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    y         = 9'(v.y);
    grad_out  = 16'(v.g);
    #1;
    check($sformatf("v%0d in_ready", k), int'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check($sformatf("v%0d lat1 valid", k), int'(out_valid), 0);
    @(posedge clk);
    #1;
    check($sformatf("v%0d lat2 valid", k), int'(out_valid), 1);
    check($sformatf("v%0d grad_in", k), int'(grad_in), v.exp);
    @(posedge clk);
    #1;
    check($sformatf("v%0d drained", k), int'(out_valid), 0);
  endtask

  initial begin
    vec_t vt[9];
    int   bb_exp[10];
    int   bp_g[3];
    int   bp_exp[3];
    int   idx;
    int   got;
    bit   acc;

    n_pass  = 0;
    n_total = 0;

    vt[0] = '{128, 256, 64};
    vt[1] = '{64, 512, 96};
    vt[2] = '{128, -256, -64};
    vt[3] = '{0, 1000, 0};
    vt[4] = '{256, 1000, 0};
    vt[5] = '{300, 1000, 0};
    vt[6] = '{192, -100, -19};
    vt[7] = '{32, 300, 32};
    vt[8] = '{511, 1000, 0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    y         = '0;
    grad_out  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", int'(out_valid), 0);
    check("reset in_ready", int'(in_ready), 1);
    check("reset grad_in", int'(grad_in), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run_one(vt[i], i);

    // 10 back-to-back samples, d=64 so grad_in = floor(g/4)
    for (int i = 0; i < 10; i++) bb_exp[i] = (i - 5) * 10;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      out_ready = 1'b1;
      if (i >= 2 && i < 12) begin
        check($sformatf("bb%0d valid", i - 2), int'(out_valid), 1);
        check($sformatf("bb%0d data", i - 2), int'(grad_in), bb_exp[i - 2]);
      end else if (i == 12) begin
        check("bb tail valid", int'(out_valid), 0);
      end
      if (i < 10) begin
        in_valid = 1'b1;
        y        = 9'd128;
        grad_out = 16'((i - 5) * 40);
        #1;
        check($sformatf("bb%0d in_ready", i), int'(in_ready), 1);
      end else begin
        in_valid = 1'b0;
      end
    end

    // back-pressure: 5 stalled cycles, 3 samples offered
    bp_g   = '{400, 800, 1200};
    bp_exp = '{100, 200, 300};
    idx = 0;
    got = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      out_ready = (c >= 5);
      if (idx < 3) begin
        in_valid = 1'b1;
        y        = 9'd128;
        grad_out = 16'(bp_g[idx]);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c >= 2 && c <= 4) begin
        check($sformatf("bp hold valid c%0d", c), int'(out_valid), 1);
        check($sformatf("bp hold data c%0d", c), int'(grad_in), 100);
      end
      if (c == 4) begin
        check("bp in_ready low", int'(in_ready), 0);
        check("bp accepted", idx, 2);
      end
      if (out_valid && out_ready) begin
        if (got < 3)
          check($sformatf("bp out%0d", got), int'(grad_in), bp_exp[got]);
        got++;
      end
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) idx++;
    end
    check("bp delivered count", got, 3);

    // reset with two samples in flight
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    y         = 9'd128;
    grad_out  = 16'd2000;
    @(negedge clk);
    grad_out = 16'd3000;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("pre-rst valid", int'(out_valid), 1);
    check("pre-rst in_ready", int'(in_ready), 0);
    rst = 1'b1;
    #1;
    check("rst out_valid", int'(out_valid), 0);
    check("rst in_ready", int'(in_ready), 1);
    check("rst grad_in", int'(grad_in), 0);
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (out_valid) got++;
    end
    check("no stale output", got, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sigmoid_backward.md
SIGMOID_BACKWARD -- requirements
Module: sigmoid_backward

Interface
REQ-001 SHALL have parameter INT_BIT, default 7, the integer bits of the signed gradient format.
REQ-002 SHALL have parameter FRAC_BIT, default 8, the fraction bits of all fixed-point values.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, the reset: asynchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1, the input sample is valid.
REQ-006 SHALL have port in_ready, output, 1, the block accepts the input sample this cycle.
REQ-007 SHALL have port y, input, FRAC_BIT+1, the forward sigmoid output: unsigned, 1 integer bit.
REQ-008 SHALL have port grad_out, input, INT_BIT+FRAC_BIT+1, the upstream gradient: signed two's complement.
REQ-009 SHALL have port out_valid, output, 1, grad_in is valid.
REQ-010 SHALL have port out_ready, input, 1, the consumer accepts grad_in.
REQ-011 SHALL have port grad_in, output, INT_BIT+FRAC_BIT+1, the downstream gradient: signed, same format as grad_out.

Function
REQ-012 SHALL compute grad_in = grad_out * y * (1 - y) per accepted sample, i.e. the backward pass of the sigmoid activation.
REQ-013 SHALL clamp y values above 1.0 (2^FRAC_BIT) to 1.0 before use.
REQ-014 SHALL form the derivative d = (y_c * (2^FRAC_BIT - y_c)) >> FRAC_BIT as unsigned FRAC_BIT bits; d SHALL never exceed 2^(FRAC_BIT-2).
REQ-015 SHALL form grad_in = (grad_out * d) arithmetically shifted right by FRAC_BIT, truncating toward negative infinity.
REQ-016 SHALL perform no saturation, since |d| <= 0.25 guarantees the result fits.
REQ-017 SHALL have two register stages: S1 registers d and grad_out; S2 registers grad_in.
REQ-018 SHALL have a latency of exactly 2 cycles from acceptance to out_valid when not back-pressured.
REQ-019 SHALL accept a sample only when in_valid && in_ready are both high on a clock edge.
REQ-020 SHALL transfer grad_in only when out_valid && out_ready are both high on a clock edge.
REQ-021 SHALL advance each stage when its downstream stage is empty or is being drained in the same cycle (bubble collapsing).
REQ-022 SHALL drive in_ready = !S1_valid || S1_advance, purely combinational from state and out_ready.
REQ-023 SHALL sustain full throughput of 1 sample per cycle while out_ready is held high.
REQ-024 SHALL hold at most 2 samples in flight; with out_ready low and both stages full, in_ready SHALL be low.
REQ-025 SHALL keep grad_in and out_valid stable while out_valid is high and out_ready is low.
REQ-026 SHALL preserve sample order and SHALL neither drop nor duplicate samples.
REQ-027 SHALL, on the same edge that S2 is drained and S1 moves into S2, accept a new sample into S1 if in_valid is high.

Reset
REQ-028 SHALL, on assertion of rst, immediately clear S1_valid and S2_valid, giving out_valid=0 and in_ready=1 (combinationally after reset).
REQ-029 SHALL reset the grad_in output register to 0; data registers in S1 need no reset.
REQ-030 SHALL discard all in-flight samples on rst asserted mid-operation; no output SHALL appear for them after release.

Structure
REQ-031 SHALL take the fixed-point width constants (sign, Q1.FRAC unsigned, Q-INT.FRAC signed) and the constant ONE = 2^FRAC_BIT from a shared package, sigmoid_pkg, shared with the forward sigmoid unit.
REQ-032 SHALL place the clamp and derivative computation in one combinational sub-module, sigmoid_deriv (y -> d).
REQ-033 SHALL keep the handshake control inside sigmoid_backward.

Verification (FRAC_BIT=8, INT_BIT=7)
REQ-034 SHALL verify: y=128, grad_out=256 -> d=64, grad_in=64, out_valid exactly 2 cycles after acceptance.
REQ-035 SHALL verify: y=64, grad_out=512 -> d=48, grad_in=96; and y=128, grad_out=-256 -> grad_in=-64.
REQ-036 SHALL verify: y=0, y=256 and y=300 (clamped), each with grad_out=1000 -> grad_in=0.
REQ-037 SHALL verify: 10 back-to-back samples with out_ready=1 -> 10 outputs on consecutive cycles, in order.
REQ-038 SHALL verify: out_ready=0 for 5 cycles while 3 samples are offered -> in_ready low after 2 accepted, grad_in held stable, all 3 delivered in order after out_ready=1.
REQ-039 SHALL verify: rst pulsed with 2 samples in flight -> out_valid=0 immediately, in_ready=1, no stale output after release.
